// File: rtl/serializer_stream_if.sv
// serializer_stream_if: parallel word input handshake and serial beat output of serializer_stream
interface serializer_stream_if #(
    parameter int WIDTH = 32,
    parameter int LANES = 1
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [LANES-1:0] out_data;
    logic             out_valid;
    logic             out_first;
    logic             out_last;
    modport master (
        output in_data, in_valid,
        input  in_ready, out_data, out_valid, out_first, out_last
    );
    modport slave (
        input  in_data, in_valid,
        output in_ready, out_data, out_valid, out_first, out_last
    );
endinterface

// File: rtl/serializer_stream.sv
// serializer_stream: parallel-to-serial converter with a one-word holding buffer and tick-paced beats
module serializer_stream #(
    parameter int WIDTH      = 32,
    parameter int LANES      = 1,
    parameter bit MSB_FIRST  = 1'b0,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input logic clk,
    input logic reset_n,
    input logic tick,
    serializer_stream_if.slave bus
);
    localparam int BEATS = WIDTH / LANES;
    localparam int BW = BEATS > 1 ? $clog2(BEATS) : 1;
    localparam logic [BW-1:0] LAST = BW'(BEATS - 1);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t           state;
    logic [WIDTH-1:0] hold;
    logic [WIDTH-1:0] shreg;
    logic [BW-1:0]    beat;
    logic             hold_full;
    logic             last_beat;
    logic             load_now;
    logic             accept;
    if (LANES < 1 || LANES > WIDTH || WIDTH % LANES != 0) begin : g_bad_cfg
        $error("serializer_stream: WIDTH must be a positive multiple of LANES");
    end
    assign last_beat = beat == LAST;
    // a held word moves into the shifter when idle or on the final beat, so words stream gaplessly
    assign load_now = tick & hold_full & (state == IDLE | last_beat);
    assign bus.in_ready = !hold_full | load_now;
    assign accept = bus.in_valid & bus.in_ready;
    assign bus.out_valid = state == SHIFT;
    assign bus.out_first = state == SHIFT & beat == '0;
    assign bus.out_last = state == SHIFT & last_beat;
    assign bus.out_data = state == SHIFT ? (MSB_FIRST ? shreg[WIDTH-1 -: LANES] : shreg[LANES-1:0])
                                         : {LANES{IDLE_LEVEL}};
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            hold      <= '0;
            hold_full <= 1'b0;
            shreg     <= '0;
            beat      <= '0;
        end else begin
            if (accept) hold <= bus.in_data;
            hold_full <= accept | (hold_full & !load_now);
            if (load_now) begin
                shreg <= hold;
                beat  <= '0;
                state <= SHIFT;
            end else if (tick && state == SHIFT) begin
                if (last_beat) begin
                    state <= IDLE;
                end else begin
                    beat  <= beat + 1'b1;
                    shreg <= MSB_FIRST ? shreg << LANES : shreg >> LANES;
                end
            end
        end
    end
endmodule

// File: tb/tb_serializer_stream.sv
// tb_serializer_stream: scoreboard bench for three serializer_stream configurations
module tb_serializer_stream;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic tick1 = 1'b1;
    bit   tick_div = 1'b0;
    int   tcnt = 0;
    int   checks = 0;
    int   failures = 0;
    int   run1 = 0, run2 = 0, run3 = 0;
    int   last_run1 = 0, last_run2 = 0, last_run3 = 0;
    int   waits;
    logic [9:0] q1[$];
    logic [9:0] q2[$];
    logic [9:0] q3[$];

    always #5 clk = ~clk;

    serializer_stream_if #(.WIDTH(8), .LANES(1)) b1();
    serializer_stream_if #(.WIDTH(8), .LANES(2)) b2();
    serializer_stream_if #(.WIDTH(8), .LANES(8)) b3();

    serializer_stream #(.WIDTH(8), .LANES(1), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u1 (
        .clk(clk), .reset_n(reset_n), .tick(tick1), .bus(b1));
    serializer_stream #(.WIDTH(8), .LANES(2), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) u2 (
        .clk(clk), .reset_n(reset_n), .tick(1'b1), .bus(b2));
    serializer_stream #(.WIDTH(8), .LANES(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u3 (
        .clk(clk), .reset_n(reset_n), .tick(1'b1), .bus(b3));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // push the beats a word must produce, in emission order; reps = cycles each beat lasts
    task automatic expect_word(input int u, input logic [7:0] w, input int reps);
        for (int b = 0; b < 8; b++)
            for (int r = 0; r < reps; r++)
                if (u == 1) q1.push_back({b == 0, b == 7, 7'b0, w[b]});
        if (u == 2)
            for (int b = 0; b < 4; b++) q2.push_back({b == 0, b == 3, 6'b0, w[7-2*b -: 2]});
        if (u == 3) q3.push_back({2'b11, w});
    endtask

    task automatic send(input int u, input logic [7:0] w, input int reps, output int n);
        logic rdy;
        n = 0;
        rdy = 1'b0;
        if (u == 1) begin b1.in_data = w; b1.in_valid = 1'b1; end
        if (u == 2) begin b2.in_data = w; b2.in_valid = 1'b1; end
        if (u == 3) begin b3.in_data = w; b3.in_valid = 1'b1; end
        while (n < 60) begin
            @(negedge clk);
            rdy = u == 1 ? b1.in_ready : u == 2 ? b2.in_ready : b3.in_ready;
            @(posedge clk);
            if (rdy) break;
            n++;
        end
        chk($sformatf("accept_u%0d_%02h", u, w), 32'(rdy), 1);
        if (rdy) expect_word(u, w, reps);
        #1;
    endtask

    task automatic stop_all();
        b1.in_valid = 1'b0;
        b2.in_valid = 1'b0;
        b3.in_valid = 1'b0;
    endtask

    always @(posedge clk) begin
        #1;
        tick1 = !tick_div || tcnt == 3;
        tcnt = (tcnt + 1) % 4;
    end

    always @(negedge clk) begin
        if (b1.out_valid) begin
            chk("u1_nonempty", 32'(q1.size() != 0), 1);
            if (q1.size() != 0)
                chk("u1_beat", 32'({b1.out_first, b1.out_last, 8'(b1.out_data)}), 32'(q1.pop_front()));
            run1++;
        end else if (run1 != 0) begin
            last_run1 = run1;
            run1 = 0;
        end
        if (b2.out_valid) begin
            chk("u2_nonempty", 32'(q2.size() != 0), 1);
            if (q2.size() != 0)
                chk("u2_beat", 32'({b2.out_first, b2.out_last, 8'(b2.out_data)}), 32'(q2.pop_front()));
            run2++;
        end else if (run2 != 0) begin
            last_run2 = run2;
            run2 = 0;
        end
        if (b3.out_valid) begin
            chk("u3_nonempty", 32'(q3.size() != 0), 1);
            if (q3.size() != 0)
                chk("u3_beat", 32'({b3.out_first, b3.out_last, 8'(b3.out_data)}), 32'(q3.pop_front()));
            run3++;
        end else if (run3 != 0) begin
            last_run3 = run3;
            run3 = 0;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        b1.in_valid = 1'b0; b1.in_data = '0;
        b2.in_valid = 1'b0; b2.in_data = '0;
        b3.in_valid = 1'b0; b3.in_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(b1.out_valid), 0);
        chk("rst_first", 32'(b1.out_first), 0);
        chk("rst_last", 32'(b1.out_last), 0);
        chk("rst_data_u1", 32'(b1.out_data), 0);
        chk("rst_data_u2", 32'(b2.out_data), 32'h3);
        chk("rst_ready", 32'(b1.in_ready), 1);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        send(1, 8'hA5, 1, waits);
        stop_all();
        repeat (14) @(posedge clk);
        #1;
        chk("single_run", 32'(last_run1), 8);
        chk("idle_valid", 32'(b1.out_valid), 0);
        chk("idle_data", 32'(b1.out_data), 0);
        chk("idle_ready", 32'(b1.in_ready), 1);
        send(1, 8'hA5, 1, waits);
        send(1, 8'h3C, 1, waits);
        chk("b2b_wait", 32'(waits), 0);
        stop_all();
        repeat (22) @(posedge clk);
        #1;
        chk("b2b_run", 32'(last_run1), 16);
        send(1, 8'hA5, 1, waits);
        send(1, 8'h22, 1, waits);
        send(1, 8'h11, 1, waits);
        chk("full_wait", 32'(waits), 7);
        stop_all();
        repeat (30) @(posedge clk);
        #1;
        chk("three_run", 32'(last_run1), 24);
        tick_div = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        send(1, 8'h0F, 4, waits);
        stop_all();
        repeat (50) @(posedge clk);
        #1;
        chk("div_run", 32'(last_run1), 32);
        tick_div = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        send(2, 8'hA5, 1, waits);
        stop_all();
        repeat (10) @(posedge clk);
        #1;
        chk("u2_run", 32'(last_run2), 4);
        chk("u2_idle_data", 32'(b2.out_data), 32'h3);
        send(3, 8'h11, 1, waits);
        send(3, 8'h22, 1, waits);
        chk("u3_wait", 32'(waits), 0);
        stop_all();
        repeat (6) @(posedge clk);
        #1;
        chk("u3_run", 32'(last_run3), 2);
        send(1, 8'hA5, 1, waits);
        send(1, 8'h3C, 1, waits);
        stop_all();
        repeat (2) @(posedge clk);
        #1;
        chk("pre_rst_data", 32'(b1.out_data), 1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("async_valid", 32'(b1.out_valid), 0);
        chk("async_data", 32'(b1.out_data), 0);
        chk("async_ready", 32'(b1.in_ready), 1);
        q1.delete();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        send(1, 8'h5A, 1, waits);
        stop_all();
        repeat (14) @(posedge clk);
        #1;
        chk("post_rst_run", 32'(last_run1), 8);
        chk("q1_drained", 32'(q1.size()), 0);
        chk("q2_drained", 32'(q2.size()), 0);
        chk("q3_drained", 32'(q3.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
